cam_dma_wb_writer: RTL

CAM_DMA_WB_WRITER -- requirements
Module: cam_dma_wb_writer

---
 rtl/cam_dma_wb_writer_if.sv | 34 +++
 rtl/cam_dma_wb_writer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cam_dma_wb_writer_if.sv
// Bundle between the camera DMA writer and its environment: control, pixel-word stream and Wishbone master bus.
interface cam_dma_wb_writer_if;
    logic        start_i;
    logic [31:0] base_adr_i;
    logic [23:0] word_count_i;
    logic        busy_o;
    logic        done_o;

    logic [31:0] pix_dat_i;
    logic        pix_valid_i;
    logic        pix_ready_o;

    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [2:0]  m_cti_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;

    modport master (
        input  start_i, base_adr_i, word_count_i, pix_dat_i, pix_valid_i, m_ack_i, m_dat_i,
        output busy_o, done_o, pix_ready_o,
        output m_adr_o, m_dat_o, m_cti_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o
    );

    modport slave (
        output start_i, base_adr_i, word_count_i, pix_dat_i, pix_valid_i, m_ack_i, m_dat_i,
        input  busy_o, done_o, pix_ready_o,
        input  m_adr_o, m_dat_o, m_cti_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o
    );
endinterface

// File: rtl/cam_dma_wb_writer.sv
// Camera DMA writer: buffers a pixel-word stream in a FWFT FIFO and writes it to memory
// as incrementing Wishbone bursts of up to BURST_LEN beats.
module cam_dma_wb_writer #(
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    cam_dma_wb_writer_if.master bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;
    localparam int unsigned CNT_W = 24;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
    state_t state, next_state;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level, level_d;
    logic [CNT_W-1:0]   remaining, fill, fill_d;
    logic [LVL_W-1:0]   beats_left, beats_d, burst_n;
    logic [31:0]        adr_q, dat_q, dat_d;
    logic [2:0]         cti_q, cti_d;
    logic [3:0]         sel_q;
    logic               wb_q, wb_d;
    logic               busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic               push, ack, start_acc;

    assign push      = bus.pix_valid_i & ready_q;
    assign ack       = (state == BURST) & bus.m_ack_i;
    assign start_acc = (state == IDLE) & bus.start_i;
    assign burst_n   = (remaining >= CNT_W'(BURST_LEN)) ? LVL_W'(BURST_LEN) : LVL_W'(remaining);

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start_i) next_state = (bus.word_count_i == '0) ? DONE : WAIT;
            WAIT:    if (level >= burst_n) next_state = BURST;
            BURST:   if (ack && beats_left == LVL_W'(1))
                         next_state = (remaining == CNT_W'(1)) ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        wb_d    = (next_state == BURST);
        busy_d  = (next_state != IDLE) || (state == DONE);
        done_d  = (state == DONE);
        beats_d = beats_left;
        if (state == WAIT)  beats_d = burst_n;
        else if (ack)       beats_d = beats_left - LVL_W'(1);
        cti_d = 3'b000;
        if (wb_d) cti_d = (beats_d == LVL_W'(1)) ? 3'b111 : 3'b010;
        // Head is valid on burst entry; the word behind it is valid on every non-final ack
        dat_d = dat_q;
        if (state == WAIT && wb_d) dat_d = mem[rd_ptr];
        else if (ack && wb_d)      dat_d = mem[rd_ptr + FIFO_AW'(1)];
        fill_d = fill;
        if (start_acc)  fill_d = bus.word_count_i;
        else if (push)  fill_d = fill - CNT_W'(1);
        level_d = level + LVL_W'(push) - LVL_W'(ack);
        ready_d = busy_d && (level_d != LVL_W'(DEPTH)) && (fill_d != '0);
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= bus.pix_dat_i;
    end

    // Datapath and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            remaining  <= '0;
            fill       <= '0;
            beats_left <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            cti_q      <= 3'b000;
            sel_q      <= 4'h0;
            wb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            level      <= level_d;
            fill       <= fill_d;
            beats_left <= beats_d;
            dat_q      <= dat_d;
            cti_q      <= cti_d;
            sel_q      <= wb_d ? 4'hF : 4'h0;
            wb_q       <= wb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (ack)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (start_acc) begin
                adr_q     <= bus.base_adr_i & 32'hFFFF_FFFC;
                remaining <= bus.word_count_i;
            end else if (ack) begin
                adr_q     <= adr_q + 32'd4;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign bus.m_adr_o     = adr_q;
    assign bus.m_dat_o     = dat_q;
    assign bus.m_cti_o     = cti_q;
    assign bus.m_sel_o     = sel_q;
    assign bus.m_we_o      = wb_q;
    assign bus.m_cyc_o     = wb_q;
    assign bus.m_stb_o     = wb_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.pix_ready_o = ready_q;
endmodule
